// File: rtl/sound_pkg.sv
// Shared types and constants for the sound event player: FSM states,
// melody identifiers and the packed {tone, dur} note word.
package sound_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP
  } state_t;

  localparam logic [1:0] MEL_COLLISION = 2'd0;
  localparam logic [1:0] MEL_SCORED    = 2'd1;
  localparam logic [1:0] MEL_WIN       = 2'd2;
  localparam logic [1:0] MEL_LOSE      = 2'd3;

  typedef struct packed {
    logic [3:0] tone;
    logic [3:0] dur;
  } note_t;

  localparam note_t      NOTE_END      = 8'h00;
  localparam logic [2:0] NOTE_IDX_LAST = 3'd7;

  function automatic note_t mk_note(input logic [3:0] tone, input logic [3:0] dur);
    note_t n;
    n.tone = tone;
    n.dur  = dur;
    return n;
  endfunction

endpackage

// File: rtl/sound_melody_rom.sv
// Combinational 32x8 melody table addressed by {melody_id, note_idx}.
// Any slot not listed returns the end marker.
module sound_melody_rom
  import sound_pkg::*;
(
  input  logic [4:0] addr_i,
  output note_t      note_o
);

  always_comb begin
    note_o = NOTE_END;
    case (addr_i)
      {MEL_COLLISION, 3'd0}: note_o = mk_note(4'd12, 4'd2);

      {MEL_SCORED, 3'd0}:    note_o = mk_note(4'd8,  4'd3);
      {MEL_SCORED, 3'd1}:    note_o = mk_note(4'd10, 4'd3);
      {MEL_SCORED, 3'd2}:    note_o = mk_note(4'd12, 4'd6);

      {MEL_WIN, 3'd0}:       note_o = mk_note(4'd8,  4'd4);
      {MEL_WIN, 3'd1}:       note_o = mk_note(4'd10, 4'd4);
      {MEL_WIN, 3'd2}:       note_o = mk_note(4'd12, 4'd4);
      {MEL_WIN, 3'd3}:       note_o = mk_note(4'd13, 4'd4);
      {MEL_WIN, 3'd4}:       note_o = mk_note(4'd15, 4'd10);

      {MEL_LOSE, 3'd0}:      note_o = mk_note(4'd12, 4'd6);
      {MEL_LOSE, 3'd1}:      note_o = mk_note(4'd10, 4'd6);
      {MEL_LOSE, 3'd2}:      note_o = mk_note(4'd8,  4'd6);
      {MEL_LOSE, 3'd3}:      note_o = mk_note(4'd5,  4'd12);
      default:               note_o = NOTE_END;
    endcase
  end

endmodule

// File: rtl/sound_event_player.sv
// Game sound sequencer: picks the highest-priority rising event and plays its
// melody note by note, timed in video frames. Optional: SND_COLLISION_EN.
module sound_event_player
  import sound_pkg::*;
#(
  parameter int DUR_UNIT_FRAMES = 1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       winPulse,
  input  logic       losePulse,
  input  logic       scoredPulse,
  input  logic       collisionPulse,
  output logic [3:0] tone_idx,
  output logic       sound_en,
  output logic       busy,
  output logic [1:0] melody_id,
  output logic       soundDonePulse
);

  localparam logic [3:0] PRESC_LAST = 4'(DUR_UNIT_FRAMES - 1);

  state_t     state_q, state_d;
  logic [1:0] mel_q, mel_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] tone_q, tone_d;
  logic [3:0] dur_q, dur_d;
  logic [3:0] presc_q, presc_d;
  logic       done_q, done_d;

  logic       win_prev_q, lose_prev_q, scored_prev_q;
  logic       coll_rise;
  logic       ev_vld;
  logic [1:0] ev_id;
  logic       accept;
  logic [2:0] idx_next;
  logic       next_terminal;
  note_t      rom_note;

  // Edge registers simply track the inputs, so after reset they already hold
  // the current level and a held-high input is not seen as a new event.
  always_ff @(posedge clk) begin
    win_prev_q    <= winPulse;
    lose_prev_q   <= losePulse;
    scored_prev_q <= scoredPulse;
  end

`ifdef SND_COLLISION_EN
  logic coll_prev_q;
  always_ff @(posedge clk) coll_prev_q <= collisionPulse;
  assign coll_rise = collisionPulse & ~coll_prev_q;
`else
  logic unused_collision;
  assign unused_collision = collisionPulse;
  assign coll_rise        = 1'b0;
`endif

  always_comb begin
    ev_vld = 1'b1;
    ev_id  = MEL_COLLISION;
    if (losePulse & ~lose_prev_q)          ev_id = MEL_LOSE;
    else if (winPulse & ~win_prev_q)       ev_id = MEL_WIN;
    else if (scoredPulse & ~scored_prev_q) ev_id = MEL_SCORED;
    else if (coll_rise)                    ev_id = MEL_COLLISION;
    else                                   ev_vld = 1'b0;
  end

  assign accept = ev_vld && ((state_q == S_IDLE) || (ev_id > mel_q));

  // While in the gap the table is looked up one note ahead.
  assign idx_next      = idx_q + 3'd1;
  assign next_terminal = (rom_note.dur == 4'd0) || (idx_next == NOTE_IDX_LAST);

  sound_melody_rom u_rom (
    .addr_i ({mel_q, (state_q == S_GAP) ? idx_next : idx_q}),
    .note_o (rom_note)
  );

  always_comb begin
    state_d = state_q;
    mel_d   = mel_q;
    idx_d   = idx_q;
    tone_d  = tone_q;
    dur_d   = dur_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    if (accept) begin
      state_d = S_LOAD;
      mel_d   = ev_id;
      idx_d   = '0;
      tone_d  = '0;
      dur_d   = '0;
      presc_d = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_LOAD: begin
          state_d = S_PLAY;
          tone_d  = rom_note.tone;
          dur_d   = rom_note.dur;
          presc_d = '0;
        end
        S_PLAY: begin
          if (startOfFrame) begin
            if (presc_q == PRESC_LAST) begin
              presc_d = '0;
              dur_d   = dur_q - 4'd1;
              if (dur_q <= 4'd1) state_d = S_GAP;
            end else begin
              presc_d = presc_q + 4'd1;
            end
          end
        end
        S_GAP: begin
          if (startOfFrame) begin
            if (next_terminal) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              idx_d   = '0;
              tone_d  = '0;
              dur_d   = '0;
            end else begin
              state_d = S_PLAY;
              idx_d   = idx_next;
              tone_d  = rom_note.tone;
              dur_d   = rom_note.dur;
              presc_d = '0;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      mel_q   <= MEL_COLLISION;
      idx_q   <= '0;
      tone_q  <= '0;
      dur_q   <= '0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mel_q   <= mel_d;
      idx_q   <= idx_d;
      tone_q  <= tone_d;
      dur_q   <= dur_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  assign tone_idx       = (state_q == S_PLAY) ? tone_q : 4'd0;
  assign sound_en       = (state_q == S_PLAY) && (tone_q != 4'd0);
  assign busy           = (state_q != S_IDLE);
  assign melody_id      = mel_q;
  assign soundDonePulse = done_q;

endmodule

// File: tb/tb_sound_event_player.sv
// Directed bench for sound_event_player; frames are 5 clocks long. Outputs are
// sampled on the falling edge and inputs are changed right after sampling.
module tb_sound_event_player;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       winPulse, losePulse, scoredPulse, collisionPulse;
  logic [3:0] tone_idx;
  logic       sound_en, busy, soundDonePulse;
  logic [1:0] melody_id;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_rises = 0;
  int seg_n;
  logic [5:0] seg_key [32];
  int         seg_sof [32];

  sound_event_player #(.DUR_UNIT_FRAMES(1)) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .winPulse       (winPulse),
    .losePulse      (losePulse),
    .scoredPulse    (scoredPulse),
    .collisionPulse (collisionPulse),
    .tone_idx       (tone_idx),
    .sound_en       (sound_en),
    .busy           (busy),
    .melody_id      (melody_id),
    .soundDonePulse (soundDonePulse)
  );

  always #5 clk = ~clk;

  initial begin
    int sof_cnt;
    sof_cnt      = 0;
    startOfFrame = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sof_cnt      = (sof_cnt == 4) ? 0 : sof_cnt + 1;
      startOfFrame = (sof_cnt == 0);
    end
  end

  initial begin
    logic busy_last;
    busy_last = 1'b0;
    forever begin
      @(negedge clk);
      if (busy && !busy_last) busy_rises++;
      busy_last = busy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Splits the run into segments of constant {busy, tone, en}, counting frame
  // pulses in each, until the player goes idle or the budget expires.
  task automatic record_run(input int budget, output int ndone);
    logic [5:0] key, cur;
    ndone = 0;
    seg_n = 0;
    cur   = '0;
    for (int i = 0; i < 32; i++) begin
      seg_key[i] = '0;
      seg_sof[i] = 0;
    end
    for (int c = 0; c < budget; c++) begin
      key = {busy, tone_idx, sound_en};
      if (soundDonePulse) ndone++;
      if (!busy) break;
      if (seg_n == 0 || key != cur) begin
        if (seg_n < 32) seg_n++;
        seg_key[seg_n-1] = key;
        cur = key;
      end
      if (startOfFrame) seg_sof[seg_n-1]++;
      @(negedge clk);
    end
    chk("run_ends_idle", busy, 0);
  endtask

  // notes: note i at bits [8i+:8] as {tone, dur}; each note then a 1-frame gap.
  task automatic expect_notes(input string tag, input int n, input logic [63:0] notes);
    logic [7:0] nt;
    chk({tag, "_nseg"}, seg_n, 2 * n);
    for (int i = 0; i < n; i++) begin
      nt = notes[8*i +: 8];
      chk($sformatf("%s_note%0d", tag, i), seg_key[2*i], {1'b1, nt[7:4], nt[7:4] != 4'd0});
      chk($sformatf("%s_frames%0d", tag, i), seg_sof[2*i], nt[3:0]);
      chk($sformatf("%s_gap%0d", tag, i), seg_key[2*i+1], 6'b100000);
      chk($sformatf("%s_gapfr%0d", tag, i), seg_sof[2*i+1], 1);
    end
  endtask

  initial begin
    int nd, rises0;
    resetN = 1'b0;
    winPulse = 1'b0; losePulse = 1'b0; scoredPulse = 1'b0; collisionPulse = 1'b0;
    cycles(3);
    chk("rst_busy", busy, 0);
    chk("rst_tone", tone_idx, 0);
    chk("rst_en", sound_en, 0);
    chk("rst_mel", melody_id, 0);
    chk("rst_done", soundDonePulse, 0);
    resetN = 1'b1;
    cycles(3);

    // scored melody, latency and timing
    scoredPulse = 1'b1;
    cycles(1);
    scoredPulse = 1'b0;
    chk("sc_busy_n1", busy, 1);
    chk("sc_tone_n1", tone_idx, 0);
    chk("sc_mel", melody_id, 1);
    cycles(1);
    chk("sc_tone_n2", tone_idx, 8);
    chk("sc_en_n2", sound_en, 1);
    record_run(1000, nd);
    expect_notes("sc", 3, 64'h0000_0000_00C6_A383);
    chk("sc_done", nd, 1);
    cycles(4);

    // win, then a lower event (dropped), then a higher one (abort to lose)
    winPulse = 1'b1;
    cycles(1);
    winPulse = 1'b0;
    chk("wn_mel", melody_id, 2);
    cycles(1);
    chk("wn_tone", tone_idx, 8);
    cycles(12);
    scoredPulse = 1'b1;
    cycles(1);
    scoredPulse = 1'b0;
    cycles(2);
    chk("wn_scored_ign_mel", melody_id, 2);
    chk("wn_scored_ign_busy", busy, 1);
    losePulse = 1'b1;
    cycles(1);
    losePulse = 1'b0;
    chk("ab_mel", melody_id, 3);
    chk("ab_done", soundDonePulse, 0);
    chk("ab_tone_load", tone_idx, 0);
    cycles(1);
    chk("ab_tone", tone_idx, 12);
    record_run(1000, nd);
    expect_notes("ls", 4, 64'h0000_0000_5C86_A6C6);
    chk("ls_done", nd, 1);
    cycles(4);

    // win and lose together, then reset during the second lose note
    winPulse = 1'b1;
    losePulse = 1'b1;
    cycles(1);
    chk("wl_mel", melody_id, 3);
    chk("wl_busy", busy, 1);
    cycles(1);
    chk("wl_tone", tone_idx, 12);
    for (int i = 0; i < 300; i++) begin
      if (tone_idx == 4'd10) break;
      @(negedge clk);
    end
    chk("wl_reach_note1", tone_idx, 10);
    resetN = 1'b0;
    cycles(1);
    chk("mr_busy", busy, 0);
    chk("mr_tone", tone_idx, 0);
    chk("mr_en", sound_en, 0);
    chk("mr_mel", melody_id, 0);
    chk("mr_done", soundDonePulse, 0);
    resetN = 1'b1;
    cycles(10);
    chk("mr_held_no_event", busy, 0);
    winPulse = 1'b0;
    losePulse = 1'b0;
    cycles(4);
    chk("mr_fall_no_event", busy, 0);

    // win held high for 500+ cycles: one melody only
    rises0 = busy_rises;
    winPulse = 1'b1;
    cycles(2);
    chk("wh_tone", tone_idx, 8);
    record_run(1000, nd);
    expect_notes("wh", 5, 64'h0000_00FA_D4C4_A484);
    chk("wh_done", nd, 1);
    cycles(350);
    chk("wh_idle", busy, 0);
    chk("wh_one_melody", busy_rises - rises0, 1);
    winPulse = 1'b0;
    cycles(4);

    collisionPulse = 1'b1;
    cycles(1);
    collisionPulse = 1'b0;
`ifdef SND_COLLISION_EN
    chk("co_busy", busy, 1);
    cycles(1);
    chk("co_tone", tone_idx, 12);
    record_run(1000, nd);
    expect_notes("co", 1, 64'h0000_0000_0000_00C2);
    chk("co_done", nd, 1);
`else
    chk("co_ignored_n1", busy, 0);
    cycles(5);
    chk("co_ignored_n6", busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sound_event_player.md
SOUND_EVENT_PLAYER -- requirements
Module: sound_event_player

Interface
REQ-001 SHALL have parameter DUR_UNIT_FRAMES, default 1, the number of startOfFrame pulses per note-duration unit (range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port resetN, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port startOfFrame, input, 1 bit: one-cycle pulse per video frame; it is the duration timebase.
REQ-005 SHALL have ports winPulse, losePulse and scoredPulse, each input, 1 bit: game-controller event levels/pulses. Only the rising edge of each is an event.
REQ-006 SHALL have port collisionPulse, input, 1 bit: ball-collision event. Only its rising edge is an event.
REQ-007 SHALL have port tone_idx, output, 4 bits: note index for the downstream tone generator; 0 = silence.
REQ-008 SHALL have port sound_en, output, 1 bit: tone enable.
REQ-009 SHALL have port busy, output, 1 bit: a melody is active.
REQ-010 SHALL have port melody_id, output, 2 bits: the active melody (0 collision, 1 scored, 2 win, 3 lose).
REQ-011 SHALL have port soundDonePulse, output, 1 bit: one-cycle pulse on natural melody completion.

Function
REQ-012 SHALL detect events as input rising edges, using a registered previous value of each input.
REQ-013 SHALL set event priority as lose(3) > win(2) > scored(1) > collision(0); when events coincide, only the highest is taken.
REQ-014 While busy, an event of strictly higher priority SHALL abort the current melody and start the new one; equal or lower priority events SHALL be dropped. No queue.
REQ-015 FSM states SHALL be S_IDLE, S_LOAD, S_PLAY, S_GAP.
REQ-016 S_IDLE->S_LOAD on an accepted event; S_LOAD fetches note 0 and goes to S_PLAY the next cycle.
REQ-017 Latency SHALL be: event edge seen in cycle N gives tone_idx/sound_en valid in cycle N+2 (busy=1 from N+1).
REQ-018 The note word SHALL be {tone[3:0], dur[3:0]}; dur=0 is the end marker; note index 7 is always treated as terminal.
REQ-019 In S_PLAY, the duration counter SHALL be loaded with dur at note start and decrement once per duration tick; the note ends on the tick that brings it to 0.
REQ-020 In S_PLAY, sound_en = (tone != 0).
REQ-021 S_GAP SHALL hold sound_en=0 until the next startOfFrame, then advance note_idx and return to S_PLAY, or go to S_IDLE if the next note is terminal.
REQ-022 On the S_IDLE return after natural completion: soundDonePulse=1 for one cycle; busy=0; tone_idx=0; sound_en=0. soundDonePulse SHALL NOT fire on abort.
REQ-023 An event arriving in the same cycle as a note end or melody end SHALL take precedence over advancing.
REQ-024 The duration-unit prescaler SHALL restart at each note start.
REQ-025 Melody contents (tone,dur) SHALL be:
  - collision: (12,2)
  - scored: (8,3)(10,3)(12,6)
  - win: (8,4)(10,4)(12,4)(13,4)(15,10)
  - lose: (12,6)(10,6)(8,6)(5,12)
  Each melody is followed by the end marker.

Reset
REQ-026 With resetN=0 at a clock edge: state=S_IDLE; tone_idx=0; sound_en=0; busy=0; melody_id=0; soundDonePulse=0; counters and note_idx=0; edge registers = current input values, so a held-high input is not an event after reset.
REQ-027 Reset mid-melody SHALL silence the outputs at that edge, with no soundDonePulse.

Configuration
REQ-028 Macro SND_COLLISION_EN: when defined, collision events play melody 0.
REQ-029 Without SND_COLLISION_EN, collisionPulse SHALL be ignored, the melody-0 edge logic SHALL be removed, and all other behaviour SHALL be unchanged.

Structure
REQ-030 Package sound_pkg SHALL hold: the state enum, MEL_COLLISION/MEL_SCORED/MEL_WIN/MEL_LOSE constants, the note struct, and the NOTE_END constant.
REQ-031 Sub-module sound_melody_rom SHALL be a combinational 32x8 lookup addressed by {melody_id, note_idx[2:0]}.

Verification
REQ-032 A scoredPulse rise at cycle N SHALL give busy=1 at N+1 and tone_idx=8/sound_en=1 at N+2. Tones 8, 10, 12 SHALL last 3, 3, 6 frames, each followed by a 1-frame gap. soundDonePulse SHALL fire once at the end.
REQ-033 A scoredPulse during win playback SHALL be ignored. A losePulse during win playback SHALL switch melody_id to 3 at the next tone (12), with no soundDonePulse.
REQ-034 winPulse and losePulse rising in the same cycle SHALL play lose only.
REQ-035 winPulse held high for 500 cycles SHALL trigger exactly one melody.
REQ-036 resetN low during the lose melody's second note SHALL give all outputs 0 at the next edge and no done pulse.
REQ-037 collisionPulse with SND_COLLISION_EN SHALL give tone 12 for 2 frames. Without the macro it SHALL leave busy at 0.
